// File: rtl/macc_ctrl_pkg.sv
// Shared types and default widths for the MACC dot-product sequencer.
package macc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCUM   = 3'd1,
    DRAIN   = 3'd2,
    CAPTURE = 3'd3,
    RESULT  = 3'd4
  } state_t;

  localparam int DEF_LATENCY = 3;
  localparam int DEF_WIDTH_A = 25;
  localparam int DEF_WIDTH_B = 18;
  localparam int DEF_WIDTH_P = 48;
  localparam int DEF_LEN_W   = 16;

  // Wide enough to hold LATENCY-1 for any legal LATENCY (1..4).
  localparam int DRAIN_CNT_W = 3;

endpackage

// File: rtl/macc_dot_sequencer_if.sv
// Job, operand-stream, result and MACC-side signals of the dot-product sequencer.
interface macc_dot_sequencer_if
  import macc_ctrl_pkg::*;
#(
  parameter int WIDTH_A = DEF_WIDTH_A,
  parameter int WIDTH_B = DEF_WIDTH_B,
  parameter int WIDTH_P = DEF_WIDTH_P,
  parameter int LEN_W   = DEF_LEN_W
);
  logic               start;
  logic [LEN_W-1:0]   len;
  logic [WIDTH_P-1:0] bias;
  logic               sub_mode;
  logic               busy;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH_A-1:0] in_a;
  logic [WIDTH_B-1:0] in_b;

  logic               res_valid;
  logic               res_ready;
  logic [WIDTH_P-1:0] res_data;

  logic [WIDTH_A-1:0] macc_a;
  logic [WIDTH_B-1:0] macc_b;
  logic               macc_addsub;
  logic               macc_carryin;
  logic               macc_ce;
  logic               macc_load;
  logic [WIDTH_P-1:0] macc_load_data;
  logic               macc_rst;
  logic [WIDTH_P-1:0] macc_p;

  // Sequencer view.
  modport slave (
    input  start, len, bias, sub_mode, in_valid, in_a, in_b, res_ready, macc_p,
    output busy, in_ready, res_valid, res_data,
    output macc_a, macc_b, macc_addsub, macc_carryin, macc_ce, macc_load,
    output macc_load_data, macc_rst
  );

  // Fetch logic / MACC wrapper view.
  modport master (
    output start, len, bias, sub_mode, in_valid, in_a, in_b, res_ready, macc_p,
    input  busy, in_ready, res_valid, res_data,
    input  macc_a, macc_b, macc_addsub, macc_carryin, macc_ce, macc_load,
    input  macc_load_data, macc_rst
  );

endinterface

// File: rtl/macc_drain_counter.sv
// Loadable down-counter that times the MACC pipeline drain.
module macc_drain_counter
  import macc_ctrl_pkg::*;
#(
  parameter int W = DRAIN_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && cnt != '0)
      cnt <= cnt - W'(1);
  end

  // Final drain cycle is the one where the count still reads 1.
  assign last = (cnt == W'(1));

endmodule

// File: rtl/macc_dot_sequencer.sv
// Job-level controller feeding one MACC_MACRO: streams operand pairs, drains, captures P.
module macc_dot_sequencer
  import macc_ctrl_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int WIDTH_A = DEF_WIDTH_A,
  parameter int WIDTH_B = DEF_WIDTH_B,
  parameter int WIDTH_P = DEF_WIDTH_P,
  parameter int LEN_W   = DEF_LEN_W
) (
  input logic                  CLK,
  input logic                  RST,
  macc_dot_sequencer_if.slave  bus
);

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beat_cnt;
  logic [WIDTH_P-1:0] bias_q;
  logic [WIDTH_P-1:0] res_data_q;
  logic               sub_q;
  logic               busy_q;
  logic               in_ready_q;
  logic               res_valid_q;

  logic beat;
  logic last_beat;
  logic drain;
  logic drain_last;

  assign beat      = bus.in_valid && in_ready_q;
  assign last_beat = (beat_cnt == len_q - LEN_W'(1));
  assign drain     = (state == DRAIN);

  macc_drain_counter #(.W(DRAIN_CNT_W)) u_drain (
    .clk      (CLK),
    .rst      (RST),
    .load     (beat && last_beat),
    .load_val (DRAIN_CNT_W'(LATENCY - 1)),
    .dec      (drain),
    .last     (drain_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      len_q       <= '0;
      beat_cnt    <= '0;
      bias_q      <= '0;
      res_data_q  <= '0;
      sub_q       <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q    <= bus.len;
            bias_q   <= bus.bias;
            sub_q    <= bus.sub_mode;
            beat_cnt <= '0;
            busy_q   <= 1'b1;
            // Empty job: the bias is the answer, the MACC is never clocked.
            if (bus.len == '0) begin
              res_data_q  <= bus.bias;
              res_valid_q <= 1'b1;
              state       <= RESULT;
            end else begin
              in_ready_q <= 1'b1;
              state      <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (last_beat) begin
              in_ready_q <= 1'b0;
              state      <= (LATENCY > 1) ? DRAIN : CAPTURE;
            end
          end
        end
        DRAIN: begin
          if (drain_last)
            state <= CAPTURE;
        end
        CAPTURE: begin
          res_data_q  <= bus.macc_p;
          res_valid_q <= 1'b1;
          state       <= RESULT;
        end
        RESULT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

  // CE only on beats and drain cycles, so stalls freeze the MACC pipeline intact.
  assign bus.macc_ce        = beat || drain;
  assign bus.macc_a         = beat ? bus.in_a : '0;
  assign bus.macc_b         = beat ? bus.in_b : '0;
  assign bus.macc_load      = beat && (beat_cnt == '0);
  assign bus.macc_load_data = bias_q;
  assign bus.macc_addsub    = ~sub_q;
  assign bus.macc_carryin   = 1'b0;
  assign bus.macc_rst       = RST;

endmodule

// File: tb/tb_macc_dot_sequencer.sv
// Randomized bench for macc_dot_sequencer with a behavioural MACC and a dot-product reference.
module tb_macc_dot_sequencer;
  import macc_ctrl_pkg::*;

  localparam int LAT = DEF_LATENCY;
  localparam int WA  = DEF_WIDTH_A;
  localparam int WB  = DEF_WIDTH_B;
  localparam int WP  = DEF_WIDTH_P;
  localparam int LW  = DEF_LEN_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  macc_dot_sequencer_if #(.WIDTH_A(WA), .WIDTH_B(WB), .WIDTH_P(WP), .LEN_W(LW)) bus();

  macc_dot_sequencer #(.LATENCY(LAT), .WIDTH_A(WA), .WIDTH_B(WB), .WIDTH_P(WP), .LEN_W(LW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int ce_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.macc_ce) ce_cnt <= ce_cnt + 1;

  // MACC_MACRO stand-in: LAT-1 operand stages plus the P register, all gated by CE.
  typedef struct packed {
    logic [WP-1:0] prod;
    logic          load;
    logic [WP-1:0] ld;
    logic          add;
  } mop_t;

  mop_t          stg [LAT-1];
  logic [WP-1:0] p_reg;
  assign bus.macc_p = p_reg;

  always @(posedge clk) begin
    mop_t                 cur, o;
    logic signed [WP-1:0] pr;
    logic [WP-1:0]        base;
    if (bus.macc_rst) begin
      p_reg <= '0;
      for (int i = 0; i < LAT-1; i++) stg[i] <= '0;
    end else if (bus.macc_ce) begin
      pr       = $signed(bus.macc_a) * $signed(bus.macc_b);
      cur.prod = pr;
      cur.load = bus.macc_load;
      cur.ld   = bus.macc_load_data;
      cur.add  = bus.macc_addsub;
      o        = stg[LAT-2];
      stg[0]  <= cur;
      for (int i = 1; i < LAT-1; i++) stg[i] <= stg[i-1];
      base   = o.load ? o.ld : p_reg;
      p_reg <= o.add ? base + o.prod : base - o.prod;
    end
  end

  logic [WA-1:0] pa [64];
  logic [WB-1:0] pb [64];

  task automatic chk(input string tag, input logic [WP-1:0] got, input logic [WP-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst_outputs(input logic [WP-1:0] res_exp);
    chk("rst_busy",      bus.busy,        0);
    chk("rst_in_ready",  bus.in_ready,    0);
    chk("rst_res_valid", bus.res_valid,   0);
    chk("rst_ce",        bus.macc_ce,     0);
    chk("rst_load",      bus.macc_load,   0);
    chk("rst_res_data",  bus.res_data,    res_exp);
    chk("rst_macc_a",    bus.macc_a,      0);
    chk("rst_macc_b",    bus.macc_b,      0);
    chk("rst_addsub",    bus.macc_addsub, 1);
    chk("rst_macc_rst",  bus.macc_rst,    1);
  endtask

  // gap < 0: random 0..-gap idle cycles between pairs; gap >= 0: exactly gap.
  task automatic run_job(input int n, input logic [WP-1:0] b, input bit sm,
                         input int gap, input int hold);
    logic signed [WP-1:0] expv;
    logic [WP-1:0]        held;
    int                   bcyc, ce0, g;
    bit                   seen;
    expv = $signed(b);
    for (int i = 0; i < n; i++)
      expv = sm ? expv - $signed(pa[i]) * $signed(pb[i])
                : expv + $signed(pa[i]) * $signed(pb[i]);
    ce0 = ce_cnt;
    bus.start    = 1'b1;
    bus.len      = LW'(n);
    bus.bias     = b;
    bus.sub_mode = sm;
    @(negedge clk);
    bcyc = cyc;
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, -gap)) : gap;
      if (i > 0) begin
        repeat (g) begin
          bus.in_valid = 1'b0;
          bus.in_a     = WA'($urandom);
          @(negedge clk);
          chk("gap_ce", bus.macc_ce, 0);
          tick;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_a     = pa[i];
      bus.in_b     = pb[i];
      @(negedge clk);
      chk("beat_ready", bus.in_ready, 1);
      chk("beat_ce",    bus.macc_ce, 1);
      chk("beat_a",     bus.macc_a, pa[i]);
      chk("beat_b",     bus.macc_b, pb[i]);
      chk("beat_load",  bus.macc_load, (i == 0));
      chk("beat_addsub", bus.macc_addsub, !sm);
      chk("beat_carry", bus.macc_carryin, 0);
      bcyc = cyc;
      tick;
    end
    // Keep offering a pair: it must not be taken.
    bus.in_valid = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("extra_ready", bus.in_ready, 0);
        chk("extra_a",     bus.macc_a, 0);
      end
      if (bus.res_valid) seen = 1'b1;
      else begin
        bus.in_valid = 1'b0;
        tick;
      end
    end
    bus.in_valid = 1'b0;
    if (!seen) chk("res_timeout", 0, 1);
    chk("res_latency", WP'(cyc - bcyc), (n == 0) ? 1 : LAT + 1);
    chk("res_data", bus.res_data, expv);
    if (n == 0) chk("len0_no_ce", WP'(ce_cnt - ce0), 0);
    held = bus.res_data;
    repeat (hold) begin
      tick;
      bus.start = 1'b1;
      bus.len   = LW'(1);
      @(negedge clk);
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_data",  bus.res_data, held);
      chk("hold_busy",  bus.busy, 1);
      chk("hold_ready", bus.in_ready, 0);
    end
    tick;
    bus.start     = 1'b0;
    bus.res_ready = 1'b1;
    tick;
    bus.res_ready = 1'b0;
    @(negedge clk);
    chk("res_clear", bus.res_valid, 0);
    chk("idle_busy", bus.busy, 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.bias      = '0;
    bus.sub_mode  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;
    repeat (3) tick;
    @(negedge clk);
    chk_rst_outputs('0);
    tick;
    rst = 1'b0;
    tick;

    pa[0] = WA'(2);  pb[0] = WB'(3);
    pa[1] = WA'(4);  pb[1] = WB'(5);
    pa[2] = WA'(-1); pb[2] = WB'(7);
    run_job(3, WP'(10), 1'b0, 0, 0);
    run_job(3, WP'(10), 1'b0, 4, 0);

    pa[0] = WA'(5);  pb[0] = WB'(5);
    pa[1] = WA'(3);  pb[1] = WB'(2);
    run_job(2, WP'(100), 1'b1, 0, 0);

    run_job(0, WP'(-7), 1'b0, 0, 0);

    pa[0] = WA'(6);  pb[0] = WB'(7);
    run_job(1, WP'(0), 1'b0, 0, 10);
    run_job(1, WP'(0), 1'b0, 0, 0);

    // Abandon a job two beats in; start in the reset cycle must lose.
    bus.start    = 1'b1;
    bus.len      = LW'(4);
    bus.bias     = WP'(5);
    bus.sub_mode = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (2) begin
      bus.in_valid = 1'b1;
      bus.in_a     = WA'($urandom);
      bus.in_b     = WB'($urandom);
      tick;
    end
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.len   = LW'(3);
    tick;
    @(negedge clk);
    chk_rst_outputs('0);
    tick;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    tick;
    @(negedge clk);
    chk("post_rst_busy", bus.busy, 0);
    pa[0] = WA'(1); pb[0] = WB'(1);
    run_job(1, WP'(1), 1'b0, 0, 0);

    for (int j = 0; j < 20; j++) begin
      int n;
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) begin
        pa[i] = WA'($urandom);
        pb[i] = WB'($urandom);
      end
      run_job(n, WP'({$urandom, $urandom}), 1'($urandom_range(0, 1)), -3,
              $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
